// File: rtl/pmem_responder.sv
// Behavioural 32 x 128-bit line memory answering LC-3b pmem requests after a fixed BUSY delay.
// Define PMEM_RESPONDER_RAND_LATENCY_EN to stretch each BUSY phase by 0..3 cycles from an 8-bit LFSR.
`timescale 1ns/1ps

module pmem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata
);

    localparam int LINE_W = 128;
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    op_write_q, op_write_d;
    logic [INDEX_BITS-1:0]   index_q, index_d;
    logic [LINE_W-1:0]       wline_q, wline_d;
    logic [LINE_W-1:0]       mem [LINES];
    logic                    mem_we;
    logic                    accept;
    logic [CNT_W-1:0]        lat_load;
    logic                    unused_addr_bits;

    // Offset bits and bits above the index alias onto the same line.
    assign unused_addr_bits = ^{pmem_address[15:INDEX_BITS+4], pmem_address[3:0]};

    assign accept = (state_q == IDLE) && (pmem_read || pmem_write);

`ifdef PMEM_RESPONDER_RAND_LATENCY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Extra BUSY cycles come from the value the LFSR holds before it steps.
    assign lat_load = CNT_W'(LATENCY - 1) + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign lat_load = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        op_write_d = op_write_q;
        index_d    = index_q;
        wline_d    = wline_q;
        mem_we     = 1'b0;
        pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A simultaneous read and write is treated as a write.
                    op_write_d = pmem_write;
                    index_d    = pmem_address[INDEX_BITS+3:4];
                    wline_d    = pmem_wdata;
                    cnt_d      = lat_load;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!op_write_q) begin
                        rdata_d = mem[index_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                pmem_resp = 1'b1;
                mem_we    = op_write_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Transaction payload and the array itself are never reset; the array survives rst_n.
    always_ff @(posedge clk) begin
        op_write_q <= op_write_d;
        index_q    <= index_d;
        wline_q    <= wline_d;
        if (mem_we) begin
            mem[index_q] <= wline_q;
        end
    end

    assign pmem_rdata = rdata_q;

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, number of BUSY cycles per transaction (legal 1..15).
REQ-002 SHALL have parameter INDEX_BITS, default 5, log2 of line count (32 lines of 128 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pmem_read  input  1  line read request, held high until pmem_resp.
REQ-006 SHALL have port pmem_write  input  1  line write request, held high until pmem_resp.
REQ-007 SHALL have port pmem_address  input  lc3b_pmem_addr (16)  byte address; bits [3:0] ignored.
REQ-008 SHALL have port pmem_wdata  input  lc3b_pmem_line (128)  write line.
REQ-009 SHALL have port pmem_resp  output  1  one-cycle completion pulse.
REQ-010 SHALL have port pmem_rdata  output  lc3b_pmem_line (128)  read line, valid when pmem_resp is high on a read.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP, DONE.
REQ-012 IDLE: on an edge with pmem_read or pmem_write high, SHALL latch op, address bits [INDEX_BITS+3:4], and pmem_wdata, load counter with LATENCY-1, go BUSY.
REQ-013 BUSY: counter==0 -> RESP, else decrement; occupies exactly LATENCY cycles.
REQ-014 RESP: pmem_resp SHALL be 1 for exactly one cycle, then DONE.
REQ-015 Read: pmem_rdata SHALL be registered from array[index] on the BUSY->RESP edge and held until the next read completes.
REQ-016 Write: array[index] SHALL take the latched line on the RESP->DONE edge; a read of the same line in the next transaction returns the new data.
REQ-017 DONE: one idle cycle, requests ignored, then IDLE; consecutive transactions are therefore separated by at least one non-request cycle.
REQ-018 pmem_read and pmem_write both high at accept: SHALL perform the write only.
REQ-019 Request, address, or wdata changes after accept SHALL be ignored until IDLE.
REQ-020 Address bits above INDEX_BITS+3 SHALL be ignored (aliasing by design).
REQ-021 Array contents SHALL be undefined until written; array is not reset.
REQ-022 pmem_resp SHALL never be high outside RESP.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, pmem_resp 0, pmem_rdata 0.
REQ-024 Reset during BUSY or RESP SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-025 Array contents SHALL be preserved across reset.

Configuration
REQ-026 Macro PMEM_RESPONDER_RAND_LATENCY_EN defined: SHALL include an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset value 8'hA5) advancing once per accepted request; counter load becomes LATENCY-1+lfsr[1:0] (pre-advance value), BUSY length LATENCY..LATENCY+3.
REQ-027 Macro undefined: no LFSR logic; BUSY length SHALL be exactly LATENCY.

Verification (LATENCY=4, macro undefined unless noted)
REQ-028 Write 0x0040 with line 128'h0123...CDEF held from edge 0 -> pmem_resp high only between edges 5 and 6; later read 0x0040 returns 128'h0123...CDEF with pmem_resp.
REQ-029 Read 0x0048 after writing 0x0040 -> same line returned (offset ignored); read 0x0240 -> aliases to the same line.
REQ-030 Read and write both high, address 0x0010, wdata all 1s -> single pmem_resp; subsequent read 0x0010 returns all 1s.
REQ-031 rst_n low during BUSY of write to 0x0020 (prior content 0x5A-repeated) -> pmem_resp stays 0, pmem_rdata 0; later read 0x0020 returns 0x5A-repeated.
REQ-032 Request held high continuously -> resp pulses every LATENCY+3 cycles (accept, 4 BUSY, RESP, DONE), never two consecutive cycles.
REQ-033 Macro defined: 16 back-to-back reads -> each accept-to-resp gap within 5..8 cycles, sequence matching a reference LFSR model seeded 8'hA5.
